// File: rtl/aes_arb_pkg.sv
// aes_arb_pkg: shared widths, FSM states and one-hot decode for the aes_core arbiter
package aes_arb_pkg;
  localparam int AES_KEY_W = 256;
  localparam int AES_BLK_W = 128;
  localparam int MAX_REQ = 4;
  typedef enum logic [1:0] {IDLE, OWNED, DRAIN} state_t;
  function automatic logic [1:0] oh2idx(input logic [MAX_REQ-1:0] oh);
    oh2idx = '0;
    for (int i = 0; i < MAX_REQ; i++)
      if (oh[i]) oh2idx = 2'(i);
  endfunction
endpackage

// File: rtl/aes_rr_picker.sv
// aes_rr_picker: combinational round-robin pick of the first request at or after rr_ptr
module aes_rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);
  always_comb begin
    winner = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NUM_REQ]) begin
        winner = '0;
        winner[(int'(rr_ptr) + i) % NUM_REQ] = 1'b1;
      end
    valid = |req;
  end
endmodule

// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: locked round-robin sharing of one aes_core between NUM_REQ requesters
// AES_ARB_STATS_EN adds saturating grant_cnt/viol_cnt statistics ports
module aes_core_arbiter
  import aes_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  output logic [NUM_REQ-1:0]             gnt,
  input  logic [NUM_REQ-1:0]             req_init,
  input  logic [NUM_REQ-1:0]             req_next,
  input  logic [NUM_REQ-1:0]             req_encdec,
  input  logic [NUM_REQ-1:0]             req_keylen,
  input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
  input  logic [NUM_REQ*AES_BLK_W-1:0]   req_block,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [AES_BLK_W-1:0]           req_result,
  output logic [NUM_REQ-1:0]             req_result_valid,
  output logic                           core_init,
  output logic                           core_next,
  output logic                           core_encdec,
  output logic                           core_keylen,
  output logic [AES_KEY_W-1:0]           core_key,
  output logic [AES_BLK_W-1:0]           core_block,
  input  logic                           core_ready,
  input  logic [AES_BLK_W-1:0]           core_result,
  input  logic                           core_result_valid
`ifdef AES_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]          grant_cnt,
  output logic [15:0]                    viol_cnt
`endif
);
  state_t state;
  logic [1:0] owner, rr_ptr, win_idx;
  logic [NUM_REQ-1:0] win;
  logic win_v, own, keylen_q, encdec_q;
  logic [AES_KEY_W-1:0] key_q;
  logic [AES_BLK_W-1:0] blk_q;
  aes_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req(req), .rr_ptr(rr_ptr), .winner(win), .valid(win_v)
  );
  assign win_idx = oh2idx(MAX_REQ'(win));
  assign own = state == OWNED;
  // Data follows the owner live and freezes at its last value once ownership ends
  assign core_key = own ? req_key[32'(owner)*AES_KEY_W +: AES_KEY_W] : key_q;
  assign core_block = own ? req_block[32'(owner)*AES_BLK_W +: AES_BLK_W] : blk_q;
  assign core_keylen = own ? req_keylen[owner] : keylen_q;
  assign core_encdec = own ? req_encdec[owner] : encdec_q;
  assign core_init = own & req_init[owner];
  assign core_next = own & req_next[owner];
  assign req_ready = own ? NUM_REQ'(core_ready) << owner : '0;
  assign req_result_valid = own ? NUM_REQ'(core_result_valid) << owner : '0;
  assign req_result = core_result;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '0;
      owner <= '0;
      rr_ptr <= '0;
      key_q <= '0;
      blk_q <= '0;
      keylen_q <= 1'b0;
      encdec_q <= 1'b0;
    end else begin
      if (own) begin
        key_q <= core_key;
        blk_q <= core_block;
        keylen_q <= core_keylen;
        encdec_q <= core_encdec;
      end
      unique case (state)
        IDLE: if (win_v) begin
          state <= OWNED;
          gnt <= win;
          owner <= win_idx;
        end
        OWNED: if (!req[owner]) begin
          state <= core_ready ? IDLE : DRAIN;
          gnt <= '0;
          rr_ptr <= (owner == 2'(NUM_REQ - 1)) ? 2'd0 : owner + 2'd1;
        end
        DRAIN: if (core_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef AES_ARB_STATS_EN
  logic [NUM_REQ-1:0] own_mask, viol;
  assign own_mask = own ? NUM_REQ'(1) << owner : '0;
  assign viol = (req_init | req_next) & ~own_mask;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt <= '0;
      viol_cnt <= '0;
    end else begin
      if (|viol && viol_cnt != 16'hffff) viol_cnt <= viol_cnt + 16'd1;
      for (int i = 0; i < NUM_REQ; i++)
        if (state == IDLE && win[i] && grant_cnt[i*16 +: 16] != 16'hffff)
          grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed checks of the aes_core arbiter against a behavioural core stand-in
module tb_aes_core_arbiter;
  localparam int N = 2;
  localparam logic [255:0] KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] H = 128'hdc95c078a2408989ad48a21492842087;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req, gnt, req_init, req_next, req_encdec, req_keylen, req_ready, req_result_valid;
  logic [N*256-1:0] req_key;
  logic [N*128-1:0] req_block;
  logic [127:0] req_result, core_block, core_result, m_blk;
  logic [255:0] core_key, m_key;
  logic core_init, core_next, core_encdec, core_keylen, core_ready, core_result_valid;
  logic is_next, m_kl, seen_rv, seen_core;
  logic [2:0] busy;
`ifdef AES_ARB_STATS_EN
  logic [N*16-1:0] grant_cnt;
  logic [15:0] viol_cnt;
`endif
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  aes_core_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .gnt(gnt), .req_init(req_init), .req_next(req_next),
    .req_encdec(req_encdec), .req_keylen(req_keylen), .req_key(req_key), .req_block(req_block),
    .req_ready(req_ready), .req_result(req_result), .req_result_valid(req_result_valid),
    .core_init(core_init), .core_next(core_next), .core_encdec(core_encdec), .core_keylen(core_keylen),
    .core_key(core_key), .core_block(core_block), .core_ready(core_ready), .core_result(core_result),
    .core_result_valid(core_result_valid)
`ifdef AES_ARB_STATS_EN
    , .grant_cnt(grant_cnt), .viol_cnt(viol_cnt)
`endif
  );
  // Stand-in core: 4-cycle latency, returns the known H for the reference key and a zero block
  function automatic logic [127:0] aes_model(input logic [255:0] k, input logic [127:0] b, input logic kl);
    return (k == KEY && b == '0 && kl) ? H : k[127:0] ^ b ^ {127'b0, kl};
  endfunction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_ready <= 1'b1;
      core_result_valid <= 1'b0;
      core_result <= '0;
      busy <= '0;
      is_next <= 1'b0;
      m_key <= '0;
      m_blk <= '0;
      m_kl <= 1'b0;
    end else if (core_init || core_next) begin
      core_ready <= 1'b0;
      core_result_valid <= 1'b0;
      busy <= 3'd4;
      is_next <= core_next;
      m_key <= core_key;
      m_blk <= core_block;
      m_kl <= core_keylen;
    end else if (busy != 0) begin
      busy <= busy - 3'd1;
      if (busy == 3'd1) begin
        core_ready <= 1'b1;
        if (is_next) begin
          core_result_valid <= 1'b1;
          core_result <= aes_model(m_key, m_blk, m_kl);
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input int p);
    for (int i = 0; i < 30 && !req_ready[p]; i++) tick();
  endtask
  task automatic wait_valid(input int p);
    for (int i = 0; i < 30 && !req_result_valid[p]; i++) tick();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    req = '0;
    req_init = '0;
    req_next = '0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask
  initial begin
    req = '0;
    req_init = '0;
    req_next = '0;
    req_encdec = 2'b11;
    req_keylen = 2'b11;
    req_key = {256'hfeedface_00000000_11111111_22222222_33333333_44444444_55555555_66666666, KEY};
    req_block = {128'h0123456789abcdef0123456789abcdef, 128'h0};
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 256'(gnt), 0);
    chk("rst_core_ctl", 256'({core_init, core_next, core_keylen, core_encdec}), 0);
    chk("rst_core_key", core_key, 0);
    chk("rst_req_ready", 256'(req_ready), 0);
    rst_n = 1'b1;
    tick();
    // 1: single requester, h_subkey flow
    req = 2'b01;
    #1 chk("t1_gnt_latency", 256'(gnt), 0);
    tick();
    chk("t1_gnt", 256'(gnt), 2'b01);
    chk("t1_core_key", core_key, KEY);
    chk("t1_core_keylen", 256'(core_keylen), 1);
    req_init = 2'b01;
    #1 chk("t1_core_init", 256'(core_init), 1);
    tick();
    req_init = '0;
    wait_ready(0);
    chk("t1_ready", 256'(req_ready), 2'b01);
    req_next = 2'b01;
    tick();
    req_next = '0;
    wait_valid(0);
    chk("t1_result_valid", 256'(req_result_valid), 2'b01);
    chk("t1_result", 256'(req_result), 256'(H));
    req = '0;
    tick();
    chk("t1_release", 256'(gnt), 0);
    // 2: simultaneous requests from reset
    do_reset();
    req = 2'b11;
    tick();
    chk("t2_first", 256'(gnt), 2'b01);
    req = 2'b10;
    tick();
    chk("t2_idle_gap", 256'(gnt), 0);
    tick();
    chk("t2_second", 256'(gnt), 2'b10);
    req = '0;
    tick();
    chk("t2_release", 256'(gnt), 0);
    // 3: non-owner init while port 0 owns
    req = 2'b01;
    tick();
    chk("t3_gnt", 256'(gnt), 2'b01);
    req_init = 2'b01;
    tick();
    req_init = '0;
    wait_ready(0);
    req_next = 2'b01;
    tick();
    req_next = '0;
    req_init = 2'b10;
    #1 chk("t3_blocked_init", 256'(core_init), 0);
    tick();
    req_init = '0;
    wait_valid(0);
    chk("t3_result", 256'(req_result), 256'(H));
    chk("t3_result_valid", 256'(req_result_valid), 2'b01);
`ifdef AES_ARB_STATS_EN
    chk("t3_viol_cnt", 256'(viol_cnt), 1);
`endif
    req = '0;
    tick();
    // 4: owner abandons mid-encryption
    req = 2'b01;
    tick();
    chk("t4_gnt_wrap", 256'(gnt), 2'b01);
    req_init = 2'b01;
    tick();
    req_init = '0;
    wait_ready(0);
    req_next = 2'b01;
    tick();
    req_next = '0;
    req = '0;
    tick();
    chk("t4_drain_gnt", 256'(gnt), 0);
    req_next = 2'b01;
    #1 chk("t4_next_forced", 256'(core_next), 0);
    tick();
    req_next = '0;
    req = 2'b10;
    seen_rv = 1'b0;
    seen_core = 1'b0;
    for (int i = 0; i < 30 && gnt != 2'b10; i++) begin
      seen_rv |= |req_result_valid;
      seen_core |= core_result_valid;
      tick();
    end
    chk("t4_core_finished", 256'(seen_core), 1);
    chk("t4_no_result_valid", 256'(seen_rv), 0);
    chk("t4_regrant", 256'(gnt), 2'b10);
    // 5: reset while port 1 owns
    req_init = 2'b10;
    #1 chk("t5_init_live", 256'(core_init), 1);
    rst_n = 1'b0;
    #1 chk("t5_rst_gnt", 256'(gnt), 0);
    chk("t5_rst_init", 256'(core_init), 0);
    @(posedge clk);
    #1;
    req_init = '0;
    req = '0;
    rst_n = 1'b1;
    tick();
    req = 2'b01;
    tick();
    chk("t5_clean_grant", 256'(gnt), 2'b01);
    req = '0;
    tick();
    // 6: lone requester regranted back-to-back
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req = 2'b01;
      tick();
      chk("t6_gnt", 256'(gnt), 2'b01);
      req = '0;
      tick();
      chk("t6_release", 256'(gnt), 0);
    end
`ifdef AES_ARB_STATS_EN
    chk("t6_grant_cnt0", 256'(grant_cnt[15:0]), 3);
    chk("t6_grant_cnt1", 256'(grant_cnt[31:16]), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
